// File: rtl/k_fixeddragonfly_collector.sv
// Collects radix-4 dragonfly group results into a ping-pong frame buffer in
// natural frequency order and streams each completed frame out one bin per cycle.
module k_fixeddragonfly_collector #(
    parameter int N  = 16,
    parameter int W  = 16,
    parameter int GW = $clog2(N/4)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 grp_valid,
    output logic                 grp_ready,
    input  logic [GW-1:0]        grp_idx,
    input  logic [W-1:0]         in0,
    input  logic [W-1:0]         in1,
    input  logic [W-1:0]         in2,
    input  logic [W-1:0]         in3,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 dup_err
);
    localparam int AW = $clog2(N);
    localparam int Q  = N/4;

    typedef enum logic [1:0] {S_EMPTY, S_FILLING, S_FULL, S_DRAINING} bank_st_t;

    bank_st_t       r_st [2];
    bank_st_t       w_st_nxt [2];
    logic           r_wb, r_rb;
    logic [GW-1:0]  r_gc;
    logic [Q-1:0]   r_mask [2];
    logic [AW-1:0]  r_ra;
    logic           r_dup;
    logic [W-1:0]   r_mem [2][N];

    logic           w_acc, w_out_hs, w_last_hs, w_gc_last;
    logic [W-1:0]   w_in [4];
    logic [AW-1:0]  w_addr [4];

    assign w_in[0] = in0;
    assign w_in[1] = in1;
    assign w_in[2] = in2;
    assign w_in[3] = in3;

    assign grp_ready = (r_st[r_wb] == S_EMPTY) || (r_st[r_wb] == S_FILLING);
    // flush wins over a same-cycle group: the group is dropped, not written
    assign w_acc     = grp_valid && grp_ready && !flush;
    assign w_gc_last = (r_gc == GW'(Q-1));

    assign out_valid = (r_st[r_rb] == S_FULL) || (r_st[r_rb] == S_DRAINING);
    assign w_out_hs  = out_valid && out_ready;
    assign w_last_hs = w_out_hs && (r_ra == AW'(N-1));
    assign out_data  = r_mem[r_rb][r_ra];
    assign out_idx   = r_ra;
    assign out_last  = (r_ra == AW'(N-1));
    assign dup_err   = r_dup;

    // Output k of group g belongs to bin g + k*N/4
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_addr[k] = AW'(grp_idx) + AW'(k*Q);
        end
    end

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_st_nxt[b] = r_st[b];
            case (r_st[b])
                S_EMPTY: begin
                    if (w_acc && r_wb == 1'(b))
                        w_st_nxt[b] = w_gc_last ? S_FULL : S_FILLING;
                end
                S_FILLING: begin
                    if (flush && r_wb == 1'(b))
                        w_st_nxt[b] = S_EMPTY;
                    else if (w_acc && r_wb == 1'(b) && w_gc_last)
                        w_st_nxt[b] = S_FULL;
                end
                S_FULL: begin
                    if (r_rb == 1'(b))
                        w_st_nxt[b] = w_last_hs ? S_EMPTY : S_DRAINING;
                end
                S_DRAINING: begin
                    if (w_last_hs)
                        w_st_nxt[b] = S_EMPTY;
                end
                default: w_st_nxt[b] = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st[0]   <= S_EMPTY;
            r_st[1]   <= S_EMPTY;
            r_wb      <= 1'b0;
            r_rb      <= 1'b0;
            r_gc      <= '0;
            r_mask[0] <= '0;
            r_mask[1] <= '0;
            r_ra      <= '0;
            r_dup     <= 1'b0;
        end else begin
            r_st[0] <= w_st_nxt[0];
            r_st[1] <= w_st_nxt[1];
            if (flush) begin
                r_gc         <= '0;
                r_mask[r_wb] <= '0;
            end else if (w_acc) begin
                if (r_mask[r_wb][grp_idx])
                    r_dup <= 1'b1;
                if (w_gc_last) begin
                    r_gc         <= '0;
                    r_mask[r_wb] <= '0;
                    r_wb         <= ~r_wb;
                end else begin
                    r_gc                  <= r_gc + GW'(1);
                    r_mask[r_wb][grp_idx] <= 1'b1;
                end
            end
            if (w_out_hs)
                r_ra <= w_last_hs ? '0 : r_ra + AW'(1);
            if (w_last_hs)
                r_rb <= ~r_rb;
        end
    end

    // Sample storage carries no reset; contents are only meaningful once written
    always_ff @(posedge clk) begin
        if (w_acc) begin
            for (int k = 0; k < 4; k++) begin
                r_mem[r_wb][w_addr[k]] <= w_in[k];
            end
        end
    end
endmodule

// File: tb/tb_k_fixeddragonfly_collector.sv
// Randomized bench for k_fixeddragonfly_collector against a frame-queue model.
module tb_k_fixeddragonfly_collector;
    localparam int N  = 16;
    localparam int W  = 16;
    localparam int GW = 2;
    localparam int AW = 4;

    typedef logic [N-1:0][W-1:0] frame_t;
    typedef struct packed { frame_t d; logic [N-1:0] kn; } qf_t;
    typedef struct packed { logic [GW-1:0] g; logic [3:0][W-1:0] d; } grp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          grp_valid = 1'b0;
    logic          grp_ready;
    logic [GW-1:0] grp_idx = '0;
    logic [W-1:0]  ins [4];
    logic          flush = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [AW-1:0] out_idx;
    logic          out_last;
    logic          dup_err;

    always #5 clk = ~clk;

    k_fixeddragonfly_collector #(.N(N), .W(W), .GW(GW)) dut (
        .clk(clk), .rst_n(rst_n), .grp_valid(grp_valid), .grp_ready(grp_ready),
        .grp_idx(grp_idx), .in0(ins[0]), .in1(ins[1]), .in2(ins[2]), .in3(ins[3]),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .dup_err(dup_err)
    );

    int passes = 0;
    int total  = 0;

    // Reference model: queue of completed frames, two bank images, fill progress
    qf_t          mq[$];
    frame_t       mem [2];
    logic [N-1:0] mkn [2];
    logic [3:0]   mmask;
    int           mgc, mrp, mwb, ncyc;
    bit           mdup, m_acc;
    grp_t         gq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passes++;
        else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_outs();
        chk("grp_ready", grp_ready, mq.size() < 2);
        chk("out_valid", out_valid, mq.size() > 0);
        chk("out_idx", out_idx, mrp);
        chk("out_last", out_last, mrp == N-1);
        chk("dup_err", dup_err, mdup);
        if (mq.size() > 0 && mq[0].kn[mrp])
            chk("out_data", out_data, mq[0].d[mrp]);
    endtask

    task automatic model_reset();
        mq.delete();
        mgc = 0; mmask = '0; mrp = 0; mwb = 0; mdup = 0;
    endtask

    task automatic cyc();
        bit  acc, hs;
        qf_t f;
        @(posedge clk);
        acc = grp_valid && (mq.size() < 2) && !flush;
        hs  = (mq.size() > 0) && out_ready;
        if (hs) begin
            if (mrp == N-1) begin mq.delete(0); mrp = 0; end
            else mrp++;
        end
        if (flush) begin
            mgc = 0; mmask = '0;
        end else if (acc) begin
            if (mmask[grp_idx]) mdup = 1;
            for (int k = 0; k < 4; k++) begin
                mem[mwb][int'(grp_idx) + k*(N/4)] = ins[k];
                mkn[mwb][int'(grp_idx) + k*(N/4)] = 1'b1;
            end
            mmask[grp_idx] = 1'b1;
            mgc++;
            if (mgc == N/4) begin
                f.d = mem[mwb]; f.kn = mkn[mwb];
                mq.push_back(f);
                mgc = 0; mmask = '0; mwb = 1 - mwb;
            end
        end
        m_acc = acc;
        @(negedge clk);
        check_outs();
    endtask

    task automatic step(input int vp, input int rp);
        if (gq.size() > 0 && $urandom_range(99) < vp) begin
            grp_valid = 1'b1;
            grp_idx   = gq[0].g;
            for (int k = 0; k < 4; k++) ins[k] = gq[0].d[k];
        end else begin
            grp_valid = 1'b0;
            grp_idx   = GW'($urandom);
            for (int k = 0; k < 4; k++) ins[k] = W'($urandom);
        end
        if (rp < 0) out_ready = (ncyc % 3 == 0);
        else        out_ready = ($urandom_range(99) < rp);
        cyc();
        if (m_acc) gq.delete(0);
        ncyc++;
    endtask

    task automatic drain(input int vp, input int rp);
        int n = 0;
        while ((gq.size() > 0 || mq.size() > 0) && n < 2000) begin
            step(vp, rp);
            n++;
        end
        chk("drain_bound", n < 2000, 1);
    endtask

    task automatic add(input int g, input bit rnd);
        grp_t e;
        e.g = GW'(g);
        for (int k = 0; k < 4; k++)
            e.d[k] = rnd ? W'($urandom) : {8'(g), 8'(k)};
        gq.push_back(e);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) ins[k] = '0;
        mkn[0] = '0; mkn[1] = '0;
        mem[0] = '0; mem[1] = '0;
        model_reset();
        ncyc = 0;
        repeat (2) @(negedge clk);
        check_outs();
        rst_n = 1'b1;

        // Directed frame: bin p carries {p%4, p/4}
        for (int g = 0; g < 4; g++) add(g, 0);
        drain(100, 100);

        // Three frames back to back at full rate
        for (int f = 0; f < 3; f++) for (int g = 0; g < 4; g++) add(g, 1);
        drain(100, 100);

        // Output stalls with out_ready pattern 1,0,0,...
        ncyc = 0;
        for (int g = 0; g < 4; g++) add(g, 1);
        drain(100, -1);

        // Duplicate group index, then a clean frame
        add(0, 1); add(1, 1); add(1, 1); add(3, 1);
        for (int g = 0; g < 4; g++) add(g, 1);
        drain(100, 100);

        // Flush a partial frame, with a group offered in the flush cycle
        add(0, 1); add(1, 1);
        drain(100, 100);
        grp_valid = 1'b1; grp_idx = 2'd2; flush = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) ins[k] = W'($urandom);
        cyc();
        flush = 1'b0;
        for (int g = 0; g < 4; g++) add(g, 1);
        drain(100, 100);

        // Random traffic with random group order and handshakes
        for (int i = 0; i < 24; i++) add($urandom_range(3), 1);
        drain(70, 60);
        for (int f = 0; f < 4; f++) for (int g = 0; g < 4; g++) add(g, 1);
        drain(90, 50);

        // Asynchronous reset in the middle of a drain
        for (int g = 0; g < 4; g++) add(g, 1);
        begin
            int n = 0;
            while (!(mq.size() > 0 && mrp == 7) && n < 200) begin step(100, 100); n++; end
            chk("reach_bin7", n < 200, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dup_err", dup_err, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_out_last", out_last, 0);
        model_reset();
        gq.delete();
        grp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_grp_ready", grp_ready, 1);
        for (int g = 0; g < 4; g++) add(g, 1);
        drain(100, 100);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
